mem_arbiter: RTL

- Shares the single data-memory port between instruction fetch (IFU, read-only) and the memory-access stage (MMU, load/store).
- The port is a multi-cycle request/grant/response bus with one transaction outstanding at a time.
- Fixed priority favours MMU, with a starvation guard for IFU.
- Flush support drops wrong-path fetches when the pipeline jumps.

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the shared data-memory port between instruction fetch and load/store.
// MMU has priority; a streak counter forces an IFU win after MAX_MMU_STREAK back-to-back MMU grants.
module mem_arbiter #(
  parameter int MAX_MMU_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ifu_req,
  input  logic [63:0] ifu_addr,
  output logic        ifu_ready,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  input  logic        mmu_req,
  input  logic        mmu_wen,
  input  logic [63:0] mmu_addr,
  input  logic [63:0] mmu_wdata,
  input  logic [3:0]  mmu_wlen,
  output logic        mmu_ready,
  output logic        mmu_rvalid,
  output logic [63:0] mmu_rdata,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [3:0]  mem_wlen,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  localparam int SW = $clog2(MAX_MMU_STREAK + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_owner_mmu;
  logic [63:0]   r_addr;
  logic          r_wen;
  logic [63:0]   r_wdata;
  logic [3:0]    r_wlen;
  logic          r_discard;
  logic [SW-1:0] r_streak;
  logic          r_ifu_rvalid;
  logic [31:0]   r_ifu_rdata;
  logic          r_mmu_rvalid;
  logic [63:0]   r_mmu_rdata;

  logic w_ifu_cand;
  logic w_mmu_win;
  logic w_ifu_flush;
  logic w_issue;

  // A fetch presented together with flush is already wrong-path, so it never competes.
  assign w_ifu_cand  = ifu_req & ~flush;
  assign w_mmu_win   = mmu_req & ((r_streak < SW'(MAX_MMU_STREAK)) | ~w_ifu_cand);
  assign w_ifu_flush = flush & ~r_owner_mmu;
  assign w_issue     = (r_state == S_ISSUE);

  assign mem_req   = w_issue & (mem_gnt | ~w_ifu_flush);
  assign mem_wen   = mem_req & r_wen;
  assign mem_addr  = mem_req ? r_addr  : 64'd0;
  assign mem_wdata = mem_req ? r_wdata : 64'd0;
  assign mem_wlen  = mem_req ? r_wlen  : 4'd0;

  assign ifu_ready  = w_issue & mem_gnt & ~r_owner_mmu;
  assign mmu_ready  = w_issue & mem_gnt & r_owner_mmu;
  assign ifu_rvalid = r_ifu_rvalid;
  assign ifu_rdata  = r_ifu_rdata;
  assign mmu_rvalid = r_mmu_rvalid;
  assign mmu_rdata  = r_mmu_rdata;
  assign busy       = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner_mmu  <= 1'b0;
      r_addr       <= 64'd0;
      r_wen        <= 1'b0;
      r_wdata      <= 64'd0;
      r_wlen       <= 4'd0;
      r_discard    <= 1'b0;
      r_streak     <= '0;
      r_ifu_rvalid <= 1'b0;
      r_ifu_rdata  <= 32'd0;
      r_mmu_rvalid <= 1'b0;
      r_mmu_rdata  <= 64'd0;
    end else begin
      r_ifu_rvalid <= 1'b0;
      r_mmu_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mmu_req | w_ifu_cand) begin
            r_state     <= S_ISSUE;
            r_discard   <= 1'b0;
            r_owner_mmu <= w_mmu_win;
            if (w_mmu_win) begin
              r_addr  <= mmu_addr;
              r_wen   <= mmu_wen;
              r_wdata <= mmu_wdata;
              r_wlen  <= mmu_wlen;
              if (!w_ifu_cand) begin
                r_streak <= '0;
              end else if (r_streak != SW'(MAX_MMU_STREAK)) begin
                r_streak <= r_streak + SW'(1);
              end else begin
                r_streak <= r_streak;
              end
            end else begin
              r_addr   <= ifu_addr;
              r_wen    <= 1'b0;
              r_wdata  <= 64'd0;
              r_wlen   <= 4'd0;
              r_streak <= '0;
            end
          end
        end
        S_ISSUE: begin
          // Grant beats a coincident flush; the fetch then completes but its data is dropped.
          if (mem_gnt) begin
            r_state <= S_WAIT;
            if (w_ifu_flush) begin
              r_discard <= 1'b1;
            end
          end else if (w_ifu_flush) begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (w_ifu_flush) begin
            r_discard <= 1'b1;
          end
          if (mem_rvalid) begin
            r_state <= S_IDLE;
            if (r_owner_mmu) begin
              r_mmu_rvalid <= 1'b1;
              r_mmu_rdata  <= r_wen ? 64'd0 : mem_rdata;
            end else if (!r_discard && !flush) begin
              r_ifu_rvalid <= 1'b1;
              r_ifu_rdata  <= r_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
